// File: rtl/sincos_pkg.sv
// Shared types and constants for the sincos_ctrl request controller.
// Build option SINCOS_CTRL_SWEEP_EN enables the background phase sweep source.
package sincos_pkg;

    localparam int PHASE_W = 10;
    localparam int AMP_W   = 8;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] ID_REQ0  = 2'd0;
    localparam logic [ID_W-1:0] ID_REQ1  = 2'd1;
    localparam logic [ID_W-1:0] ID_SWEEP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_id,
    output logic [1:0] gnt,
    output logic       gnt_any
);

    always_comb begin
        // NOTE: default every output first so no path leaves a value unassigned (latch).
        gnt     = req;
        gnt_any = |req;
        if (req == 2'b11) begin
            gnt = last_id ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sincos_ctrl.sv
// Request controller for the shared cos_sine unit: arbitrates two clients, holds
// the phase while the unit settles, returns a tagged result. Option: SINCOS_CTRL_SWEEP_EN.
module sincos_ctrl
    import sincos_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SINCOS_CTRL_SWEEP_EN
    input  logic               sweep_en,
    input  logic [PHASE_W-1:0] sweep_step,
`endif
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [PHASE_W-1:0] req_phase0,
    input  logic [PHASE_W-1:0] req_phase1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [AMP_W-1:0]   rsp_sine,
    output logic [AMP_W-1:0]   rsp_cos,
    output logic [PHASE_W-1:0] dp_x,
    input  logic [AMP_W-1:0]   dp_y_sine,
    input  logic [AMP_W-1:0]   dp_y_cos
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            last_id;
    logic [ID_W-1:0] tag;
    logic [1:0]      gnt;
    logic            gnt_any;
`ifdef SINCOS_CTRL_SWEEP_EN
    logic [PHASE_W-1:0] sweep_acc;
`endif

    rr_arb2 u_arb (
        .req     (req_valid),
        .last_id (last_id),
        .gnt     (gnt),
        .gnt_any (gnt_any)
    );

    assign req_ready = (state == IDLE) ? gnt : 2'b00;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_id   <= 1'b1;
            tag       <= ID_REQ0;
            dp_x      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sine  <= '0;
            rsp_cos   <= '0;
`ifdef SINCOS_CTRL_SWEEP_EN
            sweep_acc <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        dp_x    <= gnt[0] ? req_phase0 : req_phase1;
                        tag     <= gnt[0] ? ID_REQ0 : ID_REQ1;
                        last_id <= gnt[1];
                        cnt     <= '0;
                        state   <= HOLD;
                    end
`ifdef SINCOS_CTRL_SWEEP_EN
                    else if (sweep_en) begin
                        // Sweep is the idle filler: it never touches last_id.
                        dp_x      <= sweep_acc;
                        sweep_acc <= sweep_acc + sweep_step;
                        tag       <= ID_SWEEP;
                        cnt       <= '0;
                        state     <= HOLD;
                    end
`endif
                end
                HOLD: begin
                    // Quadrant correction reads live dp_x, so it must not move until capture.
                    if (cnt == CNT_W'(LATENCY)) begin
                        rsp_sine  <= dp_y_sine;
                        rsp_cos   <= dp_y_cos;
                        rsp_id    <= tag;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sincos_ctrl.sv
// Self-checking bench for sincos_ctrl with a pipelined cos_sine stand-in
// (ROM entry i = i/2). Sweep scenario runs only with SINCOS_CTRL_SWEEP_EN.
module tb_sincos_ctrl;
    import sincos_pkg::*;

    localparam int LATENCY = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [9:0] req_phase0 = '0;
    logic [9:0] req_phase1 = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_id;
    logic [7:0] rsp_sine, rsp_cos;
    logic [9:0] dp_x;
    logic [7:0] dp_y_sine, dp_y_cos;
`ifdef SINCOS_CTRL_SWEEP_EN
    logic       sweep_en = 1'b0;
    logic [9:0] sweep_step = '0;
`endif

    always #5 clk = ~clk;

    sincos_ctrl #(.LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SINCOS_CTRL_SWEEP_EN
        .sweep_en   (sweep_en),
        .sweep_step (sweep_step),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_phase0 (req_phase0),
        .req_phase1 (req_phase1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sine   (rsp_sine),
        .rsp_cos    (rsp_cos),
        .dp_x       (dp_x),
        .dp_y_sine  (dp_y_sine),
        .dp_y_cos   (dp_y_cos)
    );

    function automatic logic [7:0] rom_lu(input logic [7:0] a);
        return a >> 1;
    endfunction

    // cos_sine stand-in: registered ROM read, then registered quadrant fix-up on live dp_x.
    logic [9:0] xc;
    logic [7:0] rom_s, rom_c;
    assign xc = dp_x + 10'd256;
    always @(posedge clk) begin
        rom_s     <= rom_lu(dp_x[8] ? ~dp_x[7:0] : dp_x[7:0]);
        rom_c     <= rom_lu(xc[8] ? ~xc[7:0] : xc[7:0]);
        dp_y_sine <= dp_x[9] ? 8'd128 - rom_s : 8'd128 + rom_s;
        dp_y_cos  <= xc[9] ? 8'd128 - rom_c : 8'd128 + rom_c;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sine;
        logic [7:0] cos;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [7:0] sine_of(input logic [9:0] x);
        logic [7:0] a;
        a = x[7:0];
        case (x[9:8])
            2'd0:    return 8'd128 + rom_lu(a);
            2'd1:    return 8'd128 + rom_lu(8'd255 - a);
            2'd2:    return 8'd128 - rom_lu(a);
            default: return 8'd128 - rom_lu(8'd255 - a);
        endcase
    endfunction

    function automatic rsp_t expect_rsp(input logic [1:0] id, input logic [9:0] ph);
        rsp_t r;
        r.id   = id;
        r.sine = sine_of(ph);
        r.cos  = sine_of(ph + 10'd256);
        return r;
    endfunction

    // Waits (bounded) for rsp_valid at a negedge; lat = cycles waited, -1 on timeout.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (dp_x !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_dp_x: got %0d want 0", dp_x);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sine, rsp_cos} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%0b id=%0d sine=%0d cos=%0d want all 0",
                     rsp_valid, rsp_id, rsp_sine, rsp_cos);
        end
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int   lat;
        rsp_t e;
        @(negedge clk);
        req_phase0 = 10'd0;
        req_valid  = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant: req_ready got %b want 01", req_ready);
        end
        exp_q.push_back(expect_rsp(ID_REQ0, 10'd0));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        vectors++;
        if ({req_ready, rsp_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_pulse: req_ready=%b rsp_valid=%b want 00/0", req_ready, rsp_valid);
        end
        wait_rsp(lat);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles want 3", lat);
        end
        vectors++;
        if (lat < 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL single_rsp: no response");
        end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                miscompares++;
                $display("FAIL single_rsp: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                         rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop: rsp_valid got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_req1_hold();
        int   lat;
        int   bad;
        rsp_t e;
        @(negedge clk);
        req_phase1 = 10'd256;
        req_valid  = 2'b10;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL req1_grant: req_ready got %b want 10", req_ready);
        end
        exp_q.push_back(expect_rsp(ID_REQ1, 10'd256));
        @(negedge clk);
        req_valid  = 2'b00;
        req_phase1 = 10'd5;
        bad = 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (dp_x !== 10'd256) bad++;
            if (rsp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL req1_dp_x_hold: %0d cycles with dp_x != 256 (now %0d)", bad, dp_x);
        end
        vectors++;
        if (lat < 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL req1_rsp: no response");
        end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                miscompares++;
                $display("FAIL req1_rsp: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                         rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (dp_x !== 10'd256) begin
            miscompares++;
            $display("FAIL req1_dp_x_idle: got %0d want 256", dp_x);
        end
    endtask

    task automatic test_back_to_back();
        int   grants, rsps, last_cyc, pend_id;
        logic [1:0] exp_id;
        rsp_t e;
        grants  = 0;
        rsps    = 0;
        last_cyc = 0;
        pend_id = -1;
        @(negedge clk);
        rsp_ready  = 1'b1;
        req_phase0 = 10'd100;
        req_phase1 = 10'd700;
        req_valid  = 2'b11;
        for (int c = 0; c < 80 && rsps < 4; c++) begin
            #1;
            if (req_ready != 2'b00 && grants < 4) begin
                exp_id = 2'(grants % 2);
                vectors++;
                if (req_ready !== (exp_id == ID_REQ1 ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL b2b_grant%0d: req_ready got %b want id %0d", grants, req_ready, exp_id);
                end
                exp_q.push_back(expect_rsp(exp_id, exp_id == ID_REQ1 ? req_phase1 : req_phase0));
                if (grants > 0) begin
                    vectors++;
                    if (cyc - last_cyc != 5) begin
                        miscompares++;
                        $display("FAIL b2b_period: got %0d cycles want 5", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                pend_id  = int'(exp_id);
                grants++;
            end
            if (rsp_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d: unexpected response id=%0d", rsps, rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                        miscompares++;
                        $display("FAIL b2b_rsp%0d: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                                 rsps, rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
                    end
                end
                rsps++;
                if (rsps == 4) req_valid = 2'b00;
            end
            @(negedge clk);
            // Vary the granted client's phase only after its accept edge has passed.
            if (pend_id == 0) req_phase0 = req_phase0 + 10'd137;
            else if (pend_id == 1) req_phase1 = req_phase1 + 10'd137;
            pend_id = -1;
        end
        rsp_ready = 1'b0;
        vectors++;
        if (rsps != 4 || grants != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d grants %0d responses want 4/4", grants, rsps);
        end
    endtask

    task automatic test_stall();
        int   lat;
        int   bad;
        rsp_t e, snap;
        @(negedge clk);
        req_phase0 = 10'd512;
        req_valid  = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_grant: req_ready got %b want 01", req_ready);
        end
        exp_q.push_back(expect_rsp(ID_REQ0, 10'd512));
        @(negedge clk);
        req_phase1 = 10'd900;
        req_valid  = 2'b10;
        wait_rsp(lat);
        vectors++;
        if (lat < 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stall_rsp: no response");
        end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                miscompares++;
                $display("FAIL stall_rsp: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                         rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
            end
        end
        snap = e;
        bad  = 0;
        repeat (10) begin
            @(negedge clk);
            if ({rsp_valid, req_ready, rsp_id, rsp_sine, rsp_cos} !== {1'b1, 2'b00, snap}) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_frozen: %0d cycles changed (valid=%b ready=%b id=%0d sine=%0d cos=%0d)",
                     bad, rsp_valid, req_ready, rsp_id, rsp_sine, rsp_cos);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL stall_next_grant: rsp_valid=%b req_ready=%b want 0/10", rsp_valid, req_ready);
        end
        exp_q.push_back(expect_rsp(ID_REQ1, 10'd900));
        @(negedge clk);
        req_valid = 2'b00;
        vectors++;
        if (dp_x !== 10'd900) begin
            miscompares++;
            $display("FAIL stall_dp_x: got %0d want 900", dp_x);
        end
        wait_rsp(lat);
        vectors++;
        if (lat < 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stall_rsp2: no response");
        end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                miscompares++;
                $display("FAIL stall_rsp2: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                         rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        int   lat;
        int   bad;
        rsp_t e;
        @(negedge clk);
        req_phase0 = 10'd300;
        req_valid  = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dp_x, rsp_valid, rsp_id, rsp_sine, rsp_cos} !== 29'd0) begin
            miscompares++;
            $display("FAIL hold_reset: dp_x=%0d valid=%b id=%0d sine=%0d cos=%0d want all 0",
                     dp_x, rsp_valid, rsp_id, rsp_sine, rsp_cos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_discard: rsp_valid high %0d cycles want 0", bad);
        end
        req_phase0 = 10'd40;
        req_phase1 = 10'd600;
        req_valid  = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL hold_last_id: req_ready got %b want 01", req_ready);
        end
        exp_q.push_back(expect_rsp(ID_REQ0, 10'd40));
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(lat);
        vectors++;
        if (lat < 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL hold_rsp: no response");
        end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                miscompares++;
                $display("FAIL hold_rsp: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                         rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

`ifdef SINCOS_CTRL_SWEEP_EN
    task automatic test_sweep();
        int   rsps;
        bit   req_raised, req_granted;
        logic [9:0] ph;
        rsp_t e;
        rsps = 0;
        req_raised  = 1'b0;
        req_granted = 1'b0;
        ph = 10'd0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(expect_rsp(ID_SWEEP, ph));
            ph = ph + 10'd300;
        end
        @(negedge clk);
        rsp_ready  = 1'b1;
        sweep_step = 10'd300;
        sweep_en   = 1'b1;
        for (int c = 0; c < 100 && rsps < 6; c++) begin
            #1;
            if (req_raised && !req_granted && req_ready != 2'b00) begin
                vectors++;
                if (req_ready !== 2'b01) begin
                    miscompares++;
                    $display("FAIL sweep_client_grant: req_ready got %b want 01", req_ready);
                end
                exp_q.push_back(expect_rsp(ID_REQ0, 10'd50));
                req_granted = 1'b1;
            end
            if (rsp_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sweep_rsp%0d: unexpected response id=%0d", rsps, rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_sine, rsp_cos} !== e) begin
                        miscompares++;
                        $display("FAIL sweep_rsp%0d: got id=%0d sine=%0d cos=%0d want id=%0d sine=%0d cos=%0d",
                                 rsps, rsp_id, rsp_sine, rsp_cos, e.id, e.sine, e.cos);
                    end
                end
                rsps++;
            end else if (rsps == 4 && !req_raised && dp_x == 10'd176) begin
                req_phase0 = 10'd50;
                req_valid  = 2'b01;
                req_raised = 1'b1;
            end
            @(negedge clk);
            if (req_granted) begin
                req_valid = 2'b00;
                sweep_en  = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        sweep_en  = 1'b0;
        req_valid = 2'b00;
        vectors++;
        if (rsps != 6 || !req_granted) begin
            miscompares++;
            $display("FAIL sweep_count: got %0d responses granted=%0b want 6/1", rsps, req_granted);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_req1_hold();
        test_back_to_back();
        test_stall();
        test_reset_in_hold();
`ifdef SINCOS_CTRL_SWEEP_EN
        test_sweep();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected: %0d responses never seen want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
